// File: rtl/wptr_full_sync.sv
// wptr_full_sync -- write-side pointer and full-flag logic of an asynchronous FIFO.
//
// Brings the read domain's Gray pointer into the w_clk domain and keeps the binary
// and Gray write pointers. From the two pointers it derives the RAM write enable,
// the full flag, the free-entry count and a sticky pointer-corruption flag.
//
// Optional feature: define WPTR_FULL_SYNC_AFULL_EN to build the registered
// almost_full flag (wfree <= AFULL_LEVEL). Without it almost_full is tied to 0.
module wptr_full_sync #(
  parameter  int DEPTH       = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int AFULL_LEVEL = 2,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          w_clk,
  input  logic          rst_n,
  input  logic          winc,
  input  logic [AW:0]   rptr_gray,
  output logic [AW:0]   wptr_gray,
  output logic [AW-1:0] waddr,
  output logic          wen,
  output logic          wfull,
  output logic [AW:0]   wfree,
  output logic          almost_full,
  output logic          rptr_adv,
  output logic          sync_err
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  // Parameter legality is checked at elaboration so a bad instance never builds.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wptr_full_sync: DEPTH must be a power of two and at least 4");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("wptr_full_sync: SYNC_STAGES must be in 2..4");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH - 1) begin : g_bad_afull
    $error("wptr_full_sync: AFULL_LEVEL must be in 1..DEPTH-1");
  end

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Synchroniser chain: index 0 is the first stage, SYNC_STAGES-1 is rq.
  logic [SYNC_STAGES-1:0][AW:0] r_sync;

  logic [AW:0] r_wbin;
  logic [AW:0] r_wptr_gray;
  logic        r_wfull;
  logic [AW:0] r_wfree;
  logic [AW:0] r_rq_prev;
  logic        r_rptr_adv;
  logic        r_sync_err;

  logic [AW:0] w_rq;
  logic [AW:0] w_rbin;
  logic        w_wen;
  logic [AW:0] w_wbin_next;
  logic [AW:0] w_wgray_next;
  logic [AW:0] w_rq_full_pattern;
  logic        w_wfull_next;
  logic [AW:0] w_wfree_next;
  logic [AW:0] w_occ_now;
  logic        w_err_now;
  logic        w_rq_changed;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  assign w_rq   = r_sync[SYNC_STAGES-1];
  assign w_rbin = gray2bin(w_rq);

  // A write is accepted only while the FIFO is not full; a refused winc has no effect.
  assign w_wen        = winc & ~r_wfull;
  assign w_wbin_next  = r_wbin + {{AW{1'b0}}, w_wen};
  assign w_wgray_next = bin2gray(w_wbin_next);

  // Full: write pointer is exactly one lap ahead of the read pointer. In Gray code
  // that is rq with its two MSBs inverted and the lower bits equal.
  assign w_rq_full_pattern = {~w_rq[AW:AW-1], w_rq[AW-2:0]};
  assign w_wfull_next      = (w_wgray_next == w_rq_full_pattern);

  // Free count from the synchronised (and therefore late) read pointer, so it can
  // only under-report free space. Modulo arithmetic handles pointer wrap.
  assign w_wfree_next = DEPTH_W - (w_wbin_next - w_rbin);

  // Occupancy beyond DEPTH is impossible for healthy pointers.
  assign w_occ_now = r_wbin - w_rbin;
  assign w_err_now = (w_occ_now > DEPTH_W);

  assign w_rq_changed = (w_rq != r_rq_prev);

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // Shift the read pointer through the synchroniser flops.
  always_ff @(posedge w_clk or negedge rst_n) begin
    // NOTE: the synchroniser stages are ordinary flops, not a memory, so they are
    // reset; otherwise X would flow into rq and the full/free logic after reset.
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking assignment makes every stage sample the old value of the
      // one before it, giving one flop of delay per stage rather than a wire.
      r_sync <= {r_sync[SYNC_STAGES-2:0], rptr_gray};
    end
  end

  // Advance the binary and Gray write pointers together on an accepted write.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin      <= '0;
      r_wptr_gray <= '0;
    end else begin
      r_wbin      <= w_wbin_next;
      r_wptr_gray <= w_wgray_next;
    end
  end

  // Register full flag and free count from the same next-pointer values.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wfull <= 1'b0;
      r_wfree <= DEPTH_W;
    end else begin
      r_wfull <= w_wfull_next;
      r_wfree <= w_wfree_next;
    end
  end

  // One pulse per change of rq, however many steps the read pointer jumped.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rq_prev  <= '0;
      r_rptr_adv <= 1'b0;
    end else begin
      r_rq_prev  <= w_rq;
      r_rptr_adv <= w_rq_changed;
    end
  end

  // Sticky corruption flag; only reset clears it.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_err <= 1'b0;
    end else if (w_err_now) begin
      r_sync_err <= 1'b1;
    end
  end

`ifdef WPTR_FULL_SYNC_AFULL_EN
  localparam logic [AW:0] AFULL_W = AFULL_LEVEL[AW:0];

  logic r_almost_full;

  // Almost-full tracks the next free count so it changes together with wfree.
  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_wfree_next <= AFULL_W);
    end
  end

  assign almost_full = r_almost_full;
`else
  assign almost_full = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wptr_gray = r_wptr_gray;
  assign waddr     = r_wbin[AW-1:0];
  assign wen       = w_wen;
  assign wfull     = r_wfull;
  assign wfree     = r_wfree;
  assign rptr_adv  = r_rptr_adv;
  assign sync_err  = r_sync_err;

endmodule
